// File: rtl/attn_out_streamer.sv
// attn_out_streamer: snapshots a square signed matrix on a start pulse, then
// streams it row-major over valid/ready with a last flag.
// Optional macro ATTN_STREAM_HDR_EN: two header beats (0xA5, MATRIX_SIZE)
// precede the data.
module attn_out_streamer #(
  parameter int unsigned MATRIX_SIZE = 16,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] mat_in [MATRIX_SIZE][MATRIX_SIZE],
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic                         busy,
  output logic                         dropped
);

  localparam int unsigned IDX_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_SIZE - 1);

`ifdef ATTN_STREAM_HDR_EN
  typedef enum logic [1:0] {IDLE, SEND, HDR0, HDR1} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t                      state, state_d;
  logic [IDX_W-1:0]            row, row_d, col, col_d;
  logic [DATA_WIDTH-1:0]       data_d;
  logic                        valid_d, last_d, busy_d, dropped_d;
  logic                        cap;
  logic                        xfer;
  logic signed [DATA_WIDTH-1:0] mbuf [MATRIX_SIZE][MATRIX_SIZE];

  assign xfer = m_valid & m_ready;

  // Snapshot buffer: written only on the capture edge, contents otherwise held.
  always_ff @(posedge clk) begin
    if (cap) mbuf <= mat_in;
  end

  // State, index and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state   <= state_d;
      row     <= row_d;
      col     <= col_d;
      m_data  <= data_d;
      m_valid <= valid_d;
      m_last  <= last_d;
      busy    <= busy_d;
      dropped <= dropped_d;
    end
  end

  // Next-state, index advance and next output values.
  always_comb begin
    state_d   = state;
    row_d     = row;
    col_d     = col;
    data_d    = m_data;
    valid_d   = m_valid;
    last_d    = m_last;
    busy_d    = busy;
    dropped_d = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cap     = 1'b1;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          row_d   = '0;
          col_d   = '0;
`ifdef ATTN_STREAM_HDR_EN
          state_d = HDR0;
          data_d  = DATA_WIDTH'(8'hA5);
          last_d  = 1'b0;
`else
          state_d = SEND;
          data_d  = mat_in[0][0];
          last_d  = (LAST_IDX == '0);
`endif
        end
      end
`ifdef ATTN_STREAM_HDR_EN
      HDR0: begin
        dropped_d = start;
        if (xfer) begin
          state_d = HDR1;
          data_d  = DATA_WIDTH'(MATRIX_SIZE);
        end
      end
      HDR1: begin
        dropped_d = start;
        if (xfer) begin
          state_d = SEND;
          data_d  = mbuf[0][0];
          last_d  = (LAST_IDX == '0);
        end
      end
`endif
      SEND: begin
        dropped_d = start;
        if (xfer) begin
          if ((row == LAST_IDX) && (col == LAST_IDX)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
          end else begin
            if (col == LAST_IDX) begin
              col_d = '0;
              row_d = row + IDX_W'(1);
            end else begin
              col_d = col + IDX_W'(1);
            end
            data_d = mbuf[row_d][col_d];
            last_d = (row_d == LAST_IDX) && (col_d == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_attn_out_streamer.sv
// Self-checking bench for attn_out_streamer: table of stream scenarios checked
// against a row-major queue model, plus a hand-written reset-mid-stream case.
module tb_attn_out_streamer;

  localparam int N = 16;
`ifdef ATTN_STREAM_HDR_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int TOTAL = N * N + HDR;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic signed [7:0] mat_in [N][N];
  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_last;
  logic              busy;
  logic              dropped;

  int checks = 0;
  int failures = 0;

  logic signed [7:0] mdl [N][N];
  logic [7:0]        expq [$];

  typedef struct {
    int pattern;     // 0: r*16+c, 1: random with [3][4] = -5
    int ready_pct;   // probability (percent) m_ready is high per cycle
    bit overwrite;   // smash mat_in to 0x80 right after capture
    int drop_beat;   // beat index at which to pulse start while busy (-1 none)
    bit drop_last;   // pulse start on the last-transfer cycle
    int exp_drops;   // expected dropped pulses
  } vec_t;

  vec_t vecs [5];

  attn_out_streamer #(.MATRIX_SIZE(N), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mat_in(mat_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Build model matrix and expected beat queue from the element rules.
  task automatic build(input int pattern);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mdl[r][c] = (pattern == 0) ? 8'((r * 16 + c) & 8'hFF) : 8'($urandom_range(255));
    if (pattern != 0) mdl[3][4] = -8'sd5;
    expq.delete();
    if (HDR != 0) begin
      expq.push_back(8'hA5);
      expq.push_back(8'(N));
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        expq.push_back(mdl[r][c]);
    mat_in = mdl;
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge after the final transfer.
  task automatic run_stream(input vec_t v);
    int  beats = 0;
    int  drops = 0;
    int  cyc = 0;
    bit  held = 1'b0;
    bit  poked = 1'b0;
    bit  prev_drop = 1'b0;
    logic [7:0] hd = '0;
    logic       hl = 1'b0;
    build(v.pattern);
    chk("idle_valid", m_valid, 0);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (v.overwrite)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mat_in[r][c] = 8'sh80;
    chk("first_valid", m_valid, 1);
    chk("first_no_drop", dropped, 0);
    while (beats < TOTAL && cyc < 4000) begin
      cyc++;
      chk("valid_held", m_valid, 1);
      chk("busy_held", busy, 1);
      if (dropped) begin
        drops++;
        if (prev_drop) chk("drop_width", 1, 0);
      end
      prev_drop = dropped;
      if (held) begin
        chk("stall_data", m_data, hd);
        chk("stall_last", m_last, hl);
      end
      m_ready = ($urandom_range(99) < 32'(v.ready_pct));
      start = 1'b0;
      if (v.drop_beat >= 0 && beats == v.drop_beat && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (v.drop_last && beats == TOTAL - 1) begin
        m_ready = 1'b1;
        start = 1'b1;
      end
      if (m_ready) begin
        chk($sformatf("data[%0d]", beats), m_data, expq[beats]);
        chk("last_flag", m_last, (beats == TOTAL - 1) ? 1 : 0);
        beats++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hd = m_data;
        hl = m_last;
      end
      @(negedge clk);
    end
    if (beats < TOTAL) chk("stream_timeout", beats, TOTAL);
    start = 1'b0;
    m_ready = 1'b0;
    if (dropped) drops++;
    chk("end_valid", m_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_last", m_last, 0);
    chk("drop_count", drops, v.exp_drops);
  endtask

  initial begin
    vecs[0] = '{pattern: 0, ready_pct: 100, overwrite: 0, drop_beat: -1, drop_last: 0, exp_drops: 0};
    vecs[1] = '{pattern: 0, ready_pct: 50,  overwrite: 0, drop_beat: -1, drop_last: 0, exp_drops: 0};
    vecs[2] = '{pattern: 1, ready_pct: 100, overwrite: 1, drop_beat: -1, drop_last: 0, exp_drops: 0};
    vecs[3] = '{pattern: 0, ready_pct: 100, overwrite: 0, drop_beat: 100, drop_last: 1, exp_drops: 2};
    vecs[4] = '{pattern: 1, ready_pct: 50,  overwrite: 1, drop_beat: 100, drop_last: 1, exp_drops: 2};

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat_in[r][c] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_data", m_data, 0);

    // Back-to-back scenarios: each new stream starts on the first idle cycle.
    for (int i = 0; i < 5; i++) run_stream(vecs[i]);

    // Reset mid-stream after 10 transfers, then a fresh stream from [0][0].
    build(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_rst_valid", m_valid, 1);
    chk("pre_rst_data", m_data, expq[10]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_busy", busy, 0);
    m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_stream(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
